// File: rtl/led_bank_arbiter.sv
// Arbitrates the 4 board LEDs among NUM_REQ sources: requester 0 has fixed priority, the rest rotate.
// Registered outputs, a new grant appears one edge after the deciding cycle; grants are held for HOLD_TICKS ticks.
module led_bank_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          TICK_DIV     = 45000000,
  parameter int          HOLD_TICKS   = 10,
  parameter logic [3:0]  IDLE_PATTERN = 4'b0000
) (
  input  logic                                          osc_clk,
  input  logic                                          gsr,
  input  logic [NUM_REQ-1:0]                            req,
  input  logic [4*NUM_REQ-1:0]                          pat,
  output logic [NUM_REQ-1:0]                            grant,
  output logic                                          owner_valid,
  output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] owner_id,
  output logic [3:0]                                    led
);

  localparam int OW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, SHARE} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q;
  logic [HW-1:0]        hold_cnt_q;
  logic [OW-1:0]        rr_ptr_q;
  logic [OW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [3:0]           led_q, led_d;
  logic                 tick;
  logic                 new_grant;
  logic [NUM_REQ-1:0]   own_mask;
  logic [OW:0]          arb_any, arb_oth;

  // Returns {found, winner}: requester 0 first, then rr_ptr+1..NUM_REQ-1, then 1..rr_ptr.
  function automatic logic [OW:0] arbitrate(input logic [NUM_REQ-1:0] v, input logic [OW-1:0] rr);
    logic          found;
    logic [OW-1:0] win;
    found = v[0];
    win   = '0;
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!found && i > int'(rr) && v[i]) begin
        found = 1'b1;
        win   = OW'(i);
      end
    end
    for (int i = 1; i < NUM_REQ; i++) begin
      if (!found && i <= int'(rr) && v[i]) begin
        found = 1'b1;
        win   = OW'(i);
      end
    end
    return {found, win};
  endfunction

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge osc_clk) begin
    if (gsr) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= OW'(NUM_REQ - 1);
      owner_q    <= '0;
      grant_q    <= '0;
      led_q      <= IDLE_PATTERN;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (new_grant)
        hold_cnt_q <= '0;
      else if (state_q == HOLD && tick && hold_cnt_q != HW'(HOLD_TICKS))
        hold_cnt_q <= hold_cnt_q + 1'b1;
      if (new_grant && owner_d != '0)
        rr_ptr_q <= owner_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      led_q      <= led_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    new_grant = 1'b0;
    own_mask  = '0;
    own_mask[owner_q] = 1'b1;
    arb_any   = arbitrate(req, rr_ptr_q);
    arb_oth   = arbitrate(req & ~own_mask, rr_ptr_q);
    case (state_q)
      IDLE: begin
        if (arb_any[OW]) begin
          state_d   = HOLD;
          owner_d   = arb_any[OW-1:0];
          new_grant = 1'b1;
        end
      end
      HOLD: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (req[0] && owner_q != '0) begin
          owner_d   = '0;
          new_grant = 1'b1;
        end else if (hold_cnt_q == HW'(HOLD_TICKS)) begin
          state_d = SHARE;
        end
      end
      SHARE: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (owner_q != '0 && arb_oth[OW]) begin
          state_d   = HOLD;
          owner_d   = arb_oth[OW-1:0];
          new_grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so led and grant change on the same edge.
  always_comb begin
    grant_d = '0;
    led_d   = IDLE_PATTERN;
    if (state_d != IDLE) begin
      grant_d[owner_d] = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (int'(owner_d) == i)
          led_d = pat[4*i +: 4];
      end
    end
  end

  assign grant       = grant_q;
  assign owner_valid = |grant_q;
  assign owner_id    = (state_q == IDLE) ? '0 : owner_q;
  assign led         = led_q;

endmodule

// File: doc/led_bank_arbiter.md
Name: led_bank_arbiter

Overview:
- Shares the 4 on-board LEDs among NUM_REQ pattern sources, for example the blink-pattern generator, a heartbeat and a fault indicator.
- Requester 0 is the fixed-priority fault/status source. Requesters 1..NUM_REQ-1 are served round-robin.
- Each grant has a minimum visible hold time, measured in prescaled ticks of the internal oscillator clock.
- Sits between the pattern sources and the top-level led pins.

Parameters:
- NUM_REQ, 4: number of requesters; legal range is 2 or more.
- TICK_DIV, 45000000: osc_clk cycles per tick (0.1 s at 450 MHz).
- HOLD_TICKS, 10: minimum ticks a grant is held before another requester may take over (1 s at the default TICK_DIV).
- IDLE_PATTERN, 4'b0000: LED value shown when no requester owns the bank.

Ports:
- osc_clk, input, 1: system clock (internal HF oscillator).
- gsr, input, 1: synchronous, active-high reset.
- req, input, NUM_REQ: request bit per requester; held high while the requester wants the bank.
- pat, input, 4*NUM_REQ: LED pattern per requester; requester i uses bits [4i+3:4i].
- grant, output, NUM_REQ: one-hot registered grant; all zero when idle.
- owner_valid, output, 1: high when grant is nonzero.
- owner_id, output, max(1,$clog2(NUM_REQ)): index of the current owner; 0 when idle.
- led, output, 4: registered LED drive.

Behaviour:
- Reset (gsr=1 at a clock edge), applied on the same edge whatever the state, mid-operation included:
  - Outputs: grant=0, owner_valid=0, owner_id=0, led=IDLE_PATTERN.
  - Internal: state=IDLE, tick_cnt=0, hold_cnt=0, rr_ptr=NUM_REQ-1.
- Tick prescaler:
  - tick_cnt is free-running, 0..TICK_DIV-1, then wraps to 0.
  - tick is high for one cycle when tick_cnt==TICK_DIV-1.
- hold_cnt:
  - Increments on each tick while in HOLD and saturates at HOLD_TICKS.
  - Cleared on every new grant; clearing wins over a coincident tick.
- Arbitration function:
  - If req[0]=1, the winner is 0.
  - Otherwise search rr_ptr+1 .. NUM_REQ-1, then wrap to 1 .. rr_ptr; the first asserted bit wins. Requester 0 is never part of this rotation.
  - rr_ptr takes the winner's index on every grant to a requester with index 1 or higher.
- States:
  - IDLE:
    - grant=0, led=IDLE_PATTERN.
    - If any req bit is set: next edge -> HOLD, grant=onehot(winner), hold_cnt=0.
  - HOLD:
    - Owner's req drops -> IDLE on the next edge. There is always a one-cycle idle bubble, even if others are requesting.
    - Otherwise, if req[0]=1 and the owner is not 0 (preemption) -> grant 0 on the next edge, stay in HOLD, hold_cnt=0. No bubble.
    - Otherwise, if hold_cnt==HOLD_TICKS -> SHARE.
  - SHARE:
    - Owner's req drops -> IDLE.
    - Otherwise, if the owner is not 0 and any other req is set -> arbitrate with the owner masked out, grant the winner directly -> HOLD, hold_cnt=0.
    - Otherwise remain in SHARE.
    - Owner 0 is never displaced while req[0]=1.
- Outputs:
  - led is registered: led <= pat slice of the owner each cycle, or IDLE_PATTERN when idle.
  - A change on the owner's pat appears on led one cycle later.
  - On a new grant, led shows the new owner's pattern on the same edge that grant changes.
- Priority of simultaneous events:
  - Reset beats everything.
  - Owner release beats preemption.
  - Preemption beats hold expiry.
  - A request arriving in the same cycle as a release waits through the idle bubble.
- grant is always one-hot or zero; owner_valid = |grant.

Test Plan (TICK_DIV=4, HOLD_TICKS=2, NUM_REQ=4, IDLE_PATTERN=0):
- Reset/idle: hold gsr=1 for 3 cycles with all req=1 -> grant=0, led=0000, owner_id=0 throughout. First grant appears 1 cycle after gsr falls: grant=0001 (requester 0 wins).
- Round-robin: req=1110, pat1=0001, pat2=0010, pat3=0100, held for 100 cycles -> owners rotate 1,2,3,1. Each owns for at least 2 ticks and at most 3 ticks (the next grant follows the SHARE cycle entered when hold_cnt reaches 2). led tracks the owner's pattern; no idle bubble between owners.
- Preemption: requester 2 in HOLD, pulse req[0]=1 with pat0=1111 -> next edge grant=0001, led=1111, hold_cnt=0. When req[0] drops: one idle cycle with led=0000, then requester 3 is granted (rr_ptr was 2).
- Release: owner 1 drops req after 1 tick -> next edge grant=0, led=0000. If req3=1, requester 3 is granted on the following edge.
- Pattern tracking and saturation: sole requester 1 holds for 40 cycles, toggling pat1 between 0101 and 1010 every 3 cycles -> led follows with 1-cycle latency; state stays in SHARE; hold_cnt stays at 2.
- Reset mid-operation: assert gsr while in SHARE with owner 3 -> next edge grant=0, led=0000, owner_id=0. After release, with all req=1110, requester 1 is granted first (rr_ptr restored to 3).
